// File: rtl/refresh_scheduler.sv
// rtl/refresh_scheduler.sv - owed-refresh counter and PREA/REF command sequencer
// Arbitrates for the DRAM command bus, then issues PRECHARGE-ALL and AUTO-REFRESH with tRP/tRFC spacing.
module refresh_scheduler #(
  parameter int T_RP        = 3,
  parameter int T_RFC       = 21,
  parameter int MAX_PENDING = 8,
  parameter int URGENT_LVL  = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh_flag,
  input  logic       ref_grant,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic       ref_busy,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [3:0] pending_cnt,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_t;

  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);
  localparam logic [3:0]       PEND_MAX = 4'(MAX_PENDING);
  localparam logic [3:0]       URG_LVL  = 4'(URGENT_LVL);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       pending_nxt;
  logic             ovf_set;
  logic             dec;

  assign dec = (state == S_REF);

  // A flag and the REF decrement on the same edge cancel; a flag at saturation is lost and flagged.
  always_comb begin
    pending_nxt = pending_cnt;
    ovf_set     = 1'b0;
    if (refresh_flag && !dec) begin
      if (pending_cnt == PEND_MAX) ovf_set = 1'b1;
      else                         pending_nxt = pending_cnt + 4'd1;
    end else if (dec && !refresh_flag) begin
      pending_nxt = pending_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      pending_cnt <= pending_nxt;
      if (ovf_set) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (pending_cnt != 4'd0 || refresh_flag) state <= S_REQ;
        end
        S_REQ: begin
          if (ref_grant) state <= S_PRE;
        end
        S_PRE: begin
          if (T_RP <= 1) begin
            state <= S_REF;
          end else begin
            state    <= S_WAIT_RP;
            wait_cnt <= RP_LOAD;
          end
        end
        S_WAIT_RP: begin
          // Exiting on the 1->0 step puts REF exactly T_RP cycles after PREA.
          if (wait_cnt <= CNT_W'(1)) begin
            state    <= S_REF;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_REF: begin
          if (T_RFC <= 1) begin
            state <= (pending_nxt != 4'd0) ? S_REQ : S_IDLE;
          end else begin
            state    <= S_WAIT_RFC;
            wait_cnt <= RFC_LOAD;
          end
        end
        S_WAIT_RFC: begin
          if (wait_cnt <= CNT_W'(1)) begin
            state    <= (pending_nxt != 4'd0) ? S_REQ : S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ref_req    = (state == S_REQ);
  assign ref_busy   = (state == S_PRE) || (state == S_WAIT_RP) ||
                      (state == S_REF) || (state == S_WAIT_RFC);
  assign cmd_valid  = (state == S_PRE) || (state == S_REF);
  assign cmd_code   = (state == S_PRE) ? 2'b01 : (state == S_REF) ? 2'b10 : 2'b00;
  assign ref_urgent = (pending_cnt >= URG_LVL);

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb/tb_refresh_scheduler.sv - directed bench for refresh_scheduler
// Default parameters: T_RP=3, T_RFC=21, MAX_PENDING=8, URGENT_LVL=4.
module tb_refresh_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       refresh_flag;
  logic       ref_grant;
  logic       ref_req;
  logic       ref_urgent;
  logic       ref_busy;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [3:0] pending_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  refresh_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .refresh_flag (refresh_flag),
    .ref_grant    (ref_grant),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .ref_busy     (ref_busy),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .pending_cnt  (pending_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flag;
    logic       grant;
    logic       req;
    logic       urg;
    logic       busy;
    logic       valid;
    logic [1:0] code;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] all_outs();
    return {ref_req, ref_urgent, ref_busy, cmd_valid, cmd_code, pending_cnt, overflow};
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    refresh_flag = 1'b0;
    ref_grant    = 1'b0;
    #1;
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_flag();
    refresh_flag = 1'b1;
    step();
    refresh_flag = 1'b0;
  endtask

  task automatic wait_cmd(input logic [1:0] code, input int bound, output bit ok);
    int n;
    n = 0;
    while (!(cmd_valid && cmd_code == code) && n < bound) begin
      step();
      n++;
    end
    ok = cmd_valid && (cmd_code == code);
  endtask

  initial begin
    bit ok;
    int bad;
    int n;
    int k_req, k_pre, k_ref, k_idle;
    logic [3:0] pend_at_ref, pend_after;

    //            flag  grant req   urg   busy  valid code   pend  ovf
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd3, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd4, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd6, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd7, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd8, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd8, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd8, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 4'd8, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd8, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd8, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 4'd8, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd7, 1'b1};

    // Single flag with grant tied high: req +1, PREA +2, REF +5, bus released +26.
    do_reset();
    ref_grant = 1'b1;
    pulse_flag();
    k_req = -1; k_pre = -1; k_ref = -1; k_idle = -1;
    pend_at_ref = 4'hf; pend_after = 4'hf;
    for (int k = 1; k <= 40; k++) begin
      if (ref_req && k_req < 0) k_req = k;
      if (cmd_valid && cmd_code == 2'b01 && k_pre < 0) k_pre = k;
      if (cmd_valid && cmd_code == 2'b10 && k_ref < 0) begin
        k_ref = k;
        pend_at_ref = pending_cnt;
      end
      if (k_ref > 0 && k == k_ref + 1) pend_after = pending_cnt;
      if (k_pre > 0 && !ref_busy && k_idle < 0) k_idle = k;
      step();
    end
    chk("t1_req_cycle",   32'(k_req),  32'd1);
    chk("t1_prea_cycle",  32'(k_pre),  32'd2);
    chk("t1_ref_cycle",   32'(k_ref),  32'd5);
    chk("t1_busy_low",    32'(k_idle), 32'd26);
    chk("t1_pend_at_ref", 32'(pend_at_ref), 32'd1);
    chk("t1_pend_after",  32'(pend_after),  32'd0);

    // Grant withheld: request held, no command, second flag accumulates.
    do_reset();
    pulse_flag();
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (!ref_req || cmd_valid) bad++;
      step();
    end
    chk("t2_held_req_no_cmd", 32'(bad), 32'd0);
    chk("t2_pend_one", 32'(pending_cnt), 32'd1);
    pulse_flag();
    chk("t2_pend_two", 32'(pending_cnt), 32'd2);
    chk("t2_no_cmd", 32'(cmd_valid), 32'd0);

    // Urgency threshold and drop after the first refresh; re-request after tRFC.
    do_reset();
    refresh_flag = 1'b1;
    repeat (4) step();
    refresh_flag = 1'b0;
    chk("t3_pend4", 32'(pending_cnt), 32'd4);
    chk("t3_urgent", 32'(ref_urgent), 32'd1);
    ref_grant = 1'b1;
    wait_cmd(2'b10, 20, ok);
    chk("t3_ref_seen", 32'(ok), 32'd1);
    step();
    chk("t3_pend3", 32'(pending_cnt), 32'd3);
    chk("t3_not_urgent", 32'(ref_urgent), 32'd0);
    n = 1;
    while (!ref_req && n < 40) begin
      step();
      n++;
    end
    chk("t3_rereq_after_trfc", 32'(n), 32'd21);

    // Table: saturation, sticky overflow, grant-to-REF command spacing.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      refresh_flag = tbl[i].flag;
      ref_grant    = tbl[i].grant;
      step();
      chk($sformatf("tbl%0d_req", i),   32'(ref_req),     32'(tbl[i].req));
      chk($sformatf("tbl%0d_urg", i),   32'(ref_urgent),  32'(tbl[i].urg));
      chk($sformatf("tbl%0d_busy", i),  32'(ref_busy),    32'(tbl[i].busy));
      chk($sformatf("tbl%0d_valid", i), 32'(cmd_valid),   32'(tbl[i].valid));
      chk($sformatf("tbl%0d_code", i),  32'(cmd_code),    32'(tbl[i].code));
      chk($sformatf("tbl%0d_pend", i),  32'(pending_cnt), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_ovf", i),   32'(overflow),    32'(tbl[i].ovf));
    end
    refresh_flag = 1'b0;
    ref_grant    = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (!overflow) bad++;
    end
    chk("t4_ovf_sticky", 32'(bad), 32'd0);
    chk("t4_pend_after_two_more", 32'(pending_cnt), 32'd5);

    // Flag on the REF-exit edge at pending=1: count holds, REQ follows tRFC directly.
    do_reset();
    ref_grant = 1'b1;
    pulse_flag();
    wait_cmd(2'b10, 20, ok);
    chk("t5_ref_seen", 32'(ok), 32'd1);
    refresh_flag = 1'b1;
    step();
    refresh_flag = 1'b0;
    chk("t5_pend_holds", 32'(pending_cnt), 32'd1);
    n = 0;
    while (ref_busy && n < 40) begin
      step();
      n++;
    end
    chk("t5_rfc_len", 32'(n), 32'd20);
    chk("t5_back_to_req", 32'(ref_req), 32'd1);

    // Reset in WAIT_RP: outputs clear asynchronously and no REF follows.
    do_reset();
    ref_grant = 1'b1;
    pulse_flag();
    wait_cmd(2'b01, 20, ok);
    chk("t6_prea_seen", 32'(ok), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_clear", 32'(all_outs()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cmd_valid || ref_req || ref_busy) bad++;
    end
    chk("t6_idle_after_reset", 32'(bad), 32'd0);
    chk("t6_pend_zero", 32'(pending_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
